// File: rtl/dmem_wb_ram.sv
// Wishbone classic data-memory responder backed by an on-chip 16-bit word RAM with byte-lane writes.
// Latency: ack/err high in the cycle after sampling edge + WAIT_STATES; one IDLE cycle between transfers.
// Backpressure: wait states stretch the cycle; cyc_i low during WAIT aborts with no write and no termination.
module dmem_wb_ram #(
    parameter int unsigned DEPTH       = 2048,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] adr_i,
    input  logic [15:0] dat_i,
    input  logic [1:0]  sel_i,
    input  logic        we_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    output logic [15:0] dat_o,
    output logic        ack_o,
    output logic        err_o
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] WIN_BYTES = 32'(2 * DEPTH);
    localparam logic [3:0]  CNT_LOAD  = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_TERM
    } state_t;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [15:0]   dat;
        logic [1:0]    sel;
        logic          we;
        logic          hit;
    } req_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        req;
    logic        go_term;
    logic        mem_wr;
    logic [31:0] off;
    req_t        live, held, cur;
    logic [15:0] mem [DEPTH];
    logic        unused_off;

    assign req        = cyc_i & stb_i;
    assign off        = adr_i - ADDR_BASE;
    assign unused_off = ^{off[31:AW+1], off[0]};

    always_comb begin
        live.idx = off[AW:1];
        live.dat = dat_i;
        live.sel = sel_i;
        live.we  = we_i;
        live.hit = (off < WIN_BYTES);
    end

    // With zero wait states TERM is entered on the sampling edge, so the live request is used directly.
    assign cur    = (state == ST_IDLE) ? live : held;
    assign mem_wr = go_term & cur.hit & cur.we & rst_n_i;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        go_term   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_nxt = ST_TERM;
                        go_term   = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (!cyc_i) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == 4'd0) begin
                    state_nxt = ST_TERM;
                    go_term   = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ST_TERM: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
            ack_o <= 1'b0;
            err_o <= 1'b0;
            dat_o <= 16'h0000;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ack_o <= go_term & cur.hit;
            err_o <= go_term & ~cur.hit;
            if (go_term && !cur.hit) begin
                dat_o <= 16'h0000;
            end else if (go_term && !cur.we) begin
                dat_o <= mem[cur.idx];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (state == ST_IDLE && req) begin
            held <= live;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_wr) begin
            if (cur.sel[1]) mem[cur.idx][15:8] <= cur.dat[15:8];
            if (cur.sel[0]) mem[cur.idx][7:0]  <= cur.dat[7:0];
        end
    end

endmodule

// File: tb/tb_dmem_wb_ram.sv
// Bench for dmem_wb_ram: three instances (0, 3 and 5 wait states) against a word/byte-valid array model.
module tb_dmem_wb_ram;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int unsigned WS_TAB [3] = '{0, 3, 5};

    logic        clk = 1'b0;
    logic        rst_n [3];
    logic [31:0] adr   [3];
    logic [15:0] wdat  [3];
    logic [1:0]  sel   [3];
    logic        we    [3];
    logic        stb   [3];
    logic        cyc   [3];
    logic [15:0] rdat  [3];
    logic        ack   [3];
    logic        err   [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_wb_ram #(
            .DEPTH      (2048),
            .ADDR_BASE  (BASE),
            .WAIT_STATES(WS_TAB[g])
        ) u_dut (
            .clk_i  (clk),
            .rst_n_i(rst_n[g]),
            .adr_i  (adr[g]),
            .dat_i  (wdat[g]),
            .sel_i  (sel[g]),
            .we_i   (we[g]),
            .stb_i  (stb[g]),
            .cyc_i  (cyc[g]),
            .dat_o  (rdat[g]),
            .ack_o  (ack[g]),
            .err_o  (err[g])
        );
    end

    int total = 0;
    int bad   = 0;

    // Reference model: word contents plus per-byte "has been written" flags.
    logic [15:0] mem_m    [3][2048];
    logic [1:0]  vld_m    [3][2048];
    logic [15:0] last_dat [3];
    logic [15:0] last_msk [3];

    typedef struct {
        int          k;
        logic [31:0] adr;
        logic [15:0] dat;
        logic [1:0]  sel;
        logic        we;
        logic        ack;
        logic        err;
        logic [15:0] rd;
    } vec_t;

    vec_t tab [17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic model(input int k, input logic [31:0] a, input logic [15:0] d, input logic [1:0] s,
                         input logic w, output logic e_ack, output logic e_err,
                         output logic [15:0] e_dat, output logic [15:0] e_msk);
        logic [31:0] off;
        int wi;
        off = a - BASE;
        if (off < 32'd4096) begin
            wi    = int'(off / 2);
            e_ack = 1'b1;
            e_err = 1'b0;
            if (w) begin
                if (s[1]) begin mem_m[k][wi][15:8] = d[15:8]; vld_m[k][wi][1] = 1'b1; end
                if (s[0]) begin mem_m[k][wi][7:0]  = d[7:0];  vld_m[k][wi][0] = 1'b1; end
            end else begin
                last_dat[k] = mem_m[k][wi];
                last_msk[k] = {{8{vld_m[k][wi][1]}}, {8{vld_m[k][wi][0]}}};
            end
        end else begin
            e_ack       = 1'b0;
            e_err       = 1'b1;
            last_dat[k] = 16'h0000;
            last_msk[k] = 16'hFFFF;
        end
        e_dat = last_dat[k];
        e_msk = last_msk[k];
    endtask

    // One complete transfer; request fields are scrambled during WAIT to show they are ignored.
    task automatic xfer(input int k, input logic [31:0] a, input logic [15:0] d, input logic [1:0] s,
                        input logic w, input logic e_ack, input logic e_err, input logic [15:0] e_dat,
                        input logic [15:0] e_msk, input string tag);
        int ws;
        ws = int'(WS_TAB[k]);
        @(negedge clk);
        adr[k] = a; wdat[k] = d; sel[k] = s; we[k] = w; cyc[k] = 1'b1; stb[k] = 1'b1;
        for (int j = 0; j <= ws; j++) begin
            @(negedge clk);
            if (j < ws) begin
                chk({tag, " early ack"}, 32'(ack[k]), 32'd0);
                chk({tag, " early err"}, 32'(err[k]), 32'd0);
                adr[k] = $urandom; wdat[k] = 16'($urandom); sel[k] = 2'($urandom); we[k] = 1'($urandom);
            end else begin
                chk({tag, " ack"}, 32'(ack[k]), 32'(e_ack));
                chk({tag, " err"}, 32'(err[k]), 32'(e_err));
                chk({tag, " dat"}, 32'(rdat[k] & e_msk), 32'(e_dat & e_msk));
            end
        end
        cyc[k] = 1'b0; stb[k] = 1'b0;
        @(negedge clk);
        chk({tag, " ack pulse"}, 32'(ack[k]), 32'd0);
        chk({tag, " err pulse"}, 32'(err[k]), 32'd0);
    endtask

    logic        m_ack, m_err;
    logic [15:0] m_dat, m_msk;
    logic [31:0] ra;
    logic [15:0] rd;
    logic [1:0]  rs;
    logic        rw;
    int          rk, rsel;

    initial begin
        tab[0]  = '{0, BASE + 32'd4,    16'hBEEF, 2'b11, 1'b1, 1'b1, 1'b0, 16'h0000};
        tab[1]  = '{0, BASE + 32'd4,    16'h0000, 2'b01, 1'b0, 1'b1, 1'b0, 16'hBEEF};
        tab[2]  = '{0, BASE + 32'd5,    16'h1234, 2'b11, 1'b1, 1'b1, 1'b0, 16'hBEEF};
        tab[3]  = '{0, BASE + 32'd4,    16'hAB00, 2'b10, 1'b1, 1'b1, 1'b0, 16'hBEEF};
        tab[4]  = '{0, BASE + 32'd4,    16'h0000, 2'b00, 1'b0, 1'b1, 1'b0, 16'hAB34};
        tab[5]  = '{0, BASE + 32'd4,    16'hFFFF, 2'b00, 1'b1, 1'b1, 1'b0, 16'hAB34};
        tab[6]  = '{0, BASE + 32'd4,    16'h0000, 2'b11, 1'b0, 1'b1, 1'b0, 16'hAB34};
        tab[7]  = '{0, BASE + 32'd0,    16'h7777, 2'b11, 1'b1, 1'b1, 1'b0, 16'hAB34};
        tab[8]  = '{0, BASE + 32'd4096, 16'h9999, 2'b11, 1'b1, 1'b0, 1'b1, 16'h0000};
        tab[9]  = '{0, BASE + 32'd0,    16'h0000, 2'b11, 1'b0, 1'b1, 1'b0, 16'h7777};
        tab[10] = '{0, BASE + 32'd4094, 16'hC0DE, 2'b11, 1'b1, 1'b1, 1'b0, 16'h7777};
        tab[11] = '{0, BASE + 32'd4095, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b0, 16'hC0DE};
        tab[12] = '{0, BASE - 32'd2,    16'h0000, 2'b11, 1'b0, 1'b0, 1'b1, 16'h0000};
        tab[13] = '{1, BASE + 32'd10,   16'h5A5A, 2'b11, 1'b1, 1'b1, 1'b0, 16'h0000};
        tab[14] = '{1, BASE + 32'd10,   16'h0000, 2'b11, 1'b0, 1'b1, 1'b0, 16'h5A5A};
        tab[15] = '{2, BASE + 32'd14,   16'h0000, 2'b11, 1'b1, 1'b1, 1'b0, 16'h0000};
        tab[16] = '{2, BASE + 32'd14,   16'h0000, 2'b10, 1'b0, 1'b1, 1'b0, 16'h0000};

        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; adr[k] = 32'd0; wdat[k] = 16'd0; sel[k] = 2'b00;
            we[k] = 1'b0; stb[k] = 1'b0; cyc[k] = 1'b0;
            last_dat[k] = 16'h0000; last_msk[k] = 16'hFFFF;
            for (int i = 0; i < 2048; i++) vld_m[k][i] = 2'b00;
        end

        #2;
        for (int k = 0; k < 3; k++) begin
            chk("reset ack", 32'(ack[k]), 32'd0);
            chk("reset err", 32'(err[k]), 32'd0);
            chk("reset dat", 32'(rdat[k]), 32'd0);
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;

        for (int i = 0; i < 17; i++) begin
            model(tab[i].k, tab[i].adr, tab[i].dat, tab[i].sel, tab[i].we, m_ack, m_err, m_dat, m_msk);
            xfer(tab[i].k, tab[i].adr, tab[i].dat, tab[i].sel, tab[i].we,
                 tab[i].ack, tab[i].err, tab[i].rd, 16'hFFFF, $sformatf("vec%0d", i));
        end

        // Back-to-back writes with req held: acks separated by exactly one low cycle.
        @(negedge clk);
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; sel[0] = 2'b11;
        adr[0] = BASE + 32'd20; wdat[0] = 16'h1111;
        model(0, BASE + 32'd20, 16'h1111, 2'b11, 1'b1, m_ack, m_err, m_dat, m_msk);
        @(negedge clk);
        chk("b2b ack1", 32'(ack[0]), 32'd1);
        adr[0] = BASE + 32'd22; wdat[0] = 16'h2222;
        model(0, BASE + 32'd22, 16'h2222, 2'b11, 1'b1, m_ack, m_err, m_dat, m_msk);
        @(negedge clk);
        chk("b2b gap", 32'(ack[0]), 32'd0);
        @(negedge clk);
        chk("b2b ack2", 32'(ack[0]), 32'd1);
        cyc[0] = 1'b0; stb[0] = 1'b0;
        @(negedge clk);
        chk("b2b drop", 32'(ack[0]), 32'd0);
        model(0, BASE + 32'd20, 16'h0, 2'b11, 1'b0, m_ack, m_err, m_dat, m_msk);
        xfer(0, BASE + 32'd20, 16'h0, 2'b11, 1'b0, m_ack, m_err, m_dat, m_msk, "b2b rd1");
        model(0, BASE + 32'd22, 16'h0, 2'b11, 1'b0, m_ack, m_err, m_dat, m_msk);
        xfer(0, BASE + 32'd22, 16'h0, 2'b11, 1'b0, m_ack, m_err, m_dat, m_msk, "b2b rd2");

        // Abort: cyc dropped two cycles into a five-wait-state write.
        @(negedge clk);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; sel[2] = 2'b11;
        adr[2] = BASE + 32'd14; wdat[2] = 16'hFFFF;
        repeat (2) @(negedge clk);
        cyc[2] = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("abort ack", 32'(ack[2]), 32'd0);
            chk("abort err", 32'(err[2]), 32'd0);
        end
        stb[2] = 1'b0;
        model(2, BASE + 32'd14, 16'h0, 2'b11, 1'b0, m_ack, m_err, m_dat, m_msk);
        xfer(2, BASE + 32'd14, 16'h0, 2'b11, 1'b0, m_ack, m_err, m_dat, m_msk, "abort rd");

        // Reset during the WAIT of a second held-request write.
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 2'b11;
        adr[1] = BASE + 32'd30; wdat[1] = 16'h3333;
        model(1, BASE + 32'd30, 16'h3333, 2'b11, 1'b1, m_ack, m_err, m_dat, m_msk);
        @(posedge clk);
        repeat (4) @(negedge clk);
        chk("rst first ack", 32'(ack[1]), 32'd1);
        wdat[1] = 16'h4444;
        @(negedge clk);
        chk("rst gap ack", 32'(ack[1]), 32'd0);
        @(negedge clk);
        rst_n[1] = 1'b0;
        #1;
        chk("rst async dat", 32'(rdat[1]), 32'd0);
        chk("rst async ack", 32'(ack[1]), 32'd0);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        last_dat[1] = 16'h0000; last_msk[1] = 16'hFFFF;
        @(negedge clk);
        rst_n[1] = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("rst no ack", 32'(ack[1]), 32'd0);
            chk("rst no err", 32'(err[1]), 32'd0);
        end
        model(1, BASE + 32'd30, 16'h0, 2'b11, 1'b0, m_ack, m_err, m_dat, m_msk);
        xfer(1, BASE + 32'd30, 16'h0, 2'b11, 1'b0, m_ack, m_err, m_dat, m_msk, "rst rd");

        // Random traffic, biased toward a few low and top words so reads hit written data.
        for (int it = 0; it < 150; it++) begin
            rk   = int'($urandom_range(0, 2));
            rsel = int'($urandom_range(0, 7));
            if (rsel == 0)      ra = BASE + 32'd4096 + $urandom_range(0, 65535);
            else if (rsel == 1) ra = BASE - 32'd1 - $urandom_range(0, 255);
            else if (rsel == 2) ra = BASE + 32'd4064 + $urandom_range(0, 31);
            else                ra = BASE + $urandom_range(0, 31);
            rd = 16'($urandom);
            rs = 2'($urandom);
            rw = 1'($urandom);
            model(rk, ra, rd, rs, rw, m_ack, m_err, m_dat, m_msk);
            xfer(rk, ra, rd, rs, rw, m_ack, m_err, m_dat, m_msk, $sformatf("rnd%0d", it));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_wb_ram.md
# dmem_wb_ram

Wishbone classic-cycle responder for the mox125 data-memory port. It terminates the 16-bit `dmem_*` bus driven by the CPU execute stage and holds a single-clock on-chip word RAM. Writes are byte-lane selected, the wait-state count is programmable, and accesses outside the RAM window get an error response. It sits between the core's data-memory initiator and the rest of the system address map.

## Interface
- `DEPTH`, 2048: number of 16-bit words in the RAM. The window is 2*DEPTH bytes.
- `ADDR_BASE`, 32'h0000_0000: byte address of word 0. It must be even.
- `WAIT_STATES`, 0: wait cycles inserted before termination. Legal range is 0..15.
- `clk_i`, in, 1: the single clock. All state changes on its rising edge.
- `rst_n_i`, in, 1: reset, asynchronous and active-low.
- `adr_i`, in, 32: byte address.
- `dat_i`, in, 16: write data.
- `sel_i`, in, 2: byte lanes. Bit 1 selects [15:8]; bit 0 selects [7:0].
- `we_i`, in, 1: 1 = write, 0 = read.
- `stb_i`, in, 1: strobe.
- `cyc_i`, in, 1: cycle valid.
- `dat_o`, out, 16: read data. Registered.
- `ack_o`, out, 1: normal termination. Registered, one-cycle pulse.
- `err_o`, out, 1: error termination. Registered, one-cycle pulse.

## Operation
- Request is `req = cyc_i & stb_i`.
- Offset is `off = adr_i - ADDR_BASE`, computed as a 32-bit unsigned wrap.
- The access is in range iff `off < 2*DEPTH`. The word index is `off[..:1]`; `adr_i[0]` is ignored.
- State machine with states IDLE, WAIT, TERM.
- IDLE:
  - On `req`, latch adr, dat, sel, we and the in-range flag.
  - If WAIT_STATES == 0, go to TERM. Otherwise load cnt = WAIT_STATES-1 and go to WAIT.
- WAIT:
  - If `cyc_i` is low, abort: go to IDLE. No write, no ack, no err.
  - Else if cnt == 0, go to TERM.
  - Else decrement cnt.
- Entering TERM (the same edge that raises `ack_o` or `err_o`):
  - In-range write: each lane with `sel[n]` set gets the latched byte. Lanes with `sel[n]` clear keep their old value. `sel == 2'b00` writes nothing but still acks.
  - In-range read: `dat_o <=` RAM word, with both lanes always returned regardless of sel. `ack_o <= 1`.
  - Out-of-range: `err_o <= 1`, `dat_o <= 16'h0000`. No RAM access.
- TERM lasts one cycle, then the block unconditionally returns to IDLE. `ack_o` and `err_o` drop back to 0.
- `ack_o` and `err_o` are never high together and never high on two consecutive cycles.
- `dat_o` holds its last value outside TERM, except after reset.
- Request fields are sampled only in IDLE. Changes to `adr_i`, `dat_i`, `sel_i` or `we_i` during WAIT or TERM are ignored.
- RAM contents are not reset and are undefined until written.

## Timing
- Reset (asynchronous, while `rst_n_i` is 0):
  - State goes to IDLE and cnt to 0.
  - `ack_o = 0`, `err_o = 0`, `dat_o = 16'h0000`.
- Reset deassertion takes effect at the next clock edge.
- Reset asserted mid-transfer (WAIT or TERM entry pending) discards the transfer and no RAM write occurs. A write already committed on the TERM-entry edge stays.
- Latency: with the request first sampled at edge E, `ack_o`/`err_o` is high during the cycle after edge E+WAIT_STATES.
  - WAIT_STATES=0 gives termination 1 cycle after sampling.
  - Read data is valid in the same cycle as `ack_o`.
- Back-to-back: after TERM, one IDLE cycle is always present. A `req` still high in that IDLE cycle is sampled as a new transfer.
  - Minimum transfer period is WAIT_STATES+2 cycles.
- Cycle drop: `cyc_i` low in IDLE means nothing happens. `cyc_i` low during WAIT aborts. `cyc_i` low in the TERM cycle does not cancel a write already committed.
- Address wrap: `adr_i` below ADDR_BASE wraps to a large `off` and errors. `off = 2*DEPTH-1` is the last legal byte address (word DEPTH-1).

## Test plan
- Reset, then a write: with `rst_n_i` low mid-clock, outputs go to 0 immediately without waiting for an edge. Release, then write 16'hBEEF to ADDR_BASE+4 with sel=11. Read it back and get 16'hBEEF with ack 1 cycle after sampling (WAIT_STATES=0).
- Byte lanes: write 16'h1234 to word 2, then write 16'hAB00 with sel=10. Read returns 16'hAB34. A further write with sel=00 leaves 16'hAB34 and still acks.
- Wait states: with WAIT_STATES=3, a read of a word holding 16'h5A5A gets ack exactly 4 cycles after sampling, high for exactly 1 cycle. The next IDLE cycle has ack low.
- Out of range (DEPTH=2048): a write to ADDR_BASE+4096 gives err 1 cycle after sampling, no ack, and `dat_o`=0. A read of word 0 afterwards is unchanged. ADDR_BASE+4094 acks normally.
- Abort: with WAIT_STATES=5, a write of 16'hFFFF to word 7 (holding 16'h0000) with `cyc_i` dropped after 2 cycles gives no ack and no err. A later read of word 7 returns 16'h0000.
- Back-to-back and reset: hold `req` high across two writes. Acks are separated by exactly one low cycle. Asserting `rst_n_i` low during the second transfer's WAIT gives no ack and leaves the first write intact.
